// File: rtl/fetch_sequencer.sv
// Y86-64 style fetch stage: decodes the bytes at pc, registers the result and steps
// pc until a control-flow instruction (wait for a resolved target) or a fault/halt (stop).
module fetch_sequencer #(
   parameter logic [63:0] RESET_PC  = 64'd0,
   parameter logic [63:0] IMEM_LAST = 64'd2047
) (
   input  logic        clk,
   input  logic        reset,
   output logic [63:0] pc,
   input  logic        imem_error,
   input  logic [7:0]  Byte0,
   input  logic [71:0] Byte19,
   input  logic        advance,
   input  logic        pc_redirect_valid,
   input  logic [63:0] pc_redirect,
   output logic        instr_valid,
   output logic [3:0]  icode,
   output logic [3:0]  ifun,
   output logic [3:0]  rA,
   output logic [3:0]  rB,
   output logic [63:0] valC,
   output logic [63:0] valP,
   output logic [1:0]  stat
);

   typedef enum logic [1:0] {RUN, WAIT_TGT, STOP} state_t;

   localparam logic [1:0] AOK = 2'd0;
   localparam logic [1:0] HLT = 2'd1;
   localparam logic [1:0] ADR = 2'd2;
   localparam logic [1:0] INS = 2'd3;

   state_t      state, state_n;
   logic [3:0]  raw_icode, raw_ifun;
   logic [3:0]  d_icode, d_ifun, d_ra, d_rb;
   logic [63:0] d_len, d_valc, d_valp, end_addr;
   logic [63:0] imm_at2, imm_at1;
   logic [1:0]  d_stat;
   logic        has_regs, fn_ok, is_cf;

   logic [63:0] pc_n, valc_n, valp_n;
   logic [3:0]  icode_n, ifun_n, ra_n, rb_n;
   logic [1:0]  stat_n;
   logic        valid_n;

   // Byte pc+2 (or pc+1) is the least significant byte of the immediate.
   always_comb begin
      imm_at2 = '0;
      imm_at1 = '0;
      for (int k = 0; k < 8; k++) begin
         imm_at2[8*k +: 8] = Byte19[63-8*k -: 8];
         imm_at1[8*k +: 8] = Byte19[71-8*k -: 8];
      end
   end

   always_comb begin
      raw_icode = Byte0[7:4];
      raw_ifun  = Byte0[3:0];
      d_len     = 64'd1;
      has_regs  = 1'b0;
      fn_ok     = 1'b0;
      d_valc    = '0;
      is_cf     = 1'b0;
      case (raw_icode)
         4'h0, 4'h1: fn_ok = (raw_ifun == 4'h0);
         4'h9: begin
            fn_ok = (raw_ifun == 4'h0);
            is_cf = 1'b1;
         end
         4'h2: begin
            d_len    = 64'd2;
            has_regs = 1'b1;
            fn_ok    = (raw_ifun <= 4'h6);
         end
         4'h6: begin
            d_len    = 64'd2;
            has_regs = 1'b1;
            fn_ok    = (raw_ifun <= 4'h3);
         end
         4'hA, 4'hB: begin
            d_len    = 64'd2;
            has_regs = 1'b1;
            fn_ok    = (raw_ifun == 4'h0);
         end
         4'h3, 4'h4, 4'h5: begin
            d_len    = 64'd10;
            has_regs = 1'b1;
            fn_ok    = (raw_ifun == 4'h0);
            d_valc   = imm_at2;
         end
         4'h7: begin
            d_len  = 64'd9;
            fn_ok  = (raw_ifun <= 4'h6);
            d_valc = imm_at1;
            is_cf  = 1'b1;
         end
         4'h8: begin
            d_len  = 64'd9;
            fn_ok  = (raw_ifun == 4'h0);
            d_valc = imm_at1;
            is_cf  = 1'b1;
         end
         default: fn_ok = 1'b0;
      endcase

      d_ra     = has_regs ? Byte19[71:68] : 4'hF;
      d_rb     = has_regs ? Byte19[67:64] : 4'hF;
      d_valp   = pc + d_len;
      end_addr = d_valp - 64'd1;
      d_icode  = raw_icode;
      d_ifun   = raw_ifun;

      if (imem_error || (end_addr > IMEM_LAST)) begin
         d_stat  = ADR;
         d_icode = 4'h0;
         d_ifun  = 4'h0;
      end else if (!fn_ok) begin
         d_stat = INS;
      end else if (raw_icode == 4'h0) begin
         d_stat = HLT;
      end else begin
         d_stat = AOK;
      end
   end

   // A redirect in WAIT_TGT only moves pc; the fetch at the new pc happens next cycle.
   always_comb begin
      state_n = state;
      pc_n    = pc;
      valid_n = instr_valid;
      icode_n = icode;
      ifun_n  = ifun;
      ra_n    = rA;
      rb_n    = rB;
      valc_n  = valC;
      valp_n  = valP;
      stat_n  = stat;
      case (state)
         RUN: begin
            if (!instr_valid || advance) begin
               valid_n = 1'b1;
               icode_n = d_icode;
               ifun_n  = d_ifun;
               ra_n    = d_ra;
               rb_n    = d_rb;
               valc_n  = d_valc;
               valp_n  = d_valp;
               stat_n  = d_stat;
               if (d_stat != AOK) begin
                  state_n = STOP;
               end else if (is_cf) begin
                  state_n = WAIT_TGT;
               end else begin
                  pc_n = d_valp;
               end
            end
         end
         WAIT_TGT: begin
            if (advance) begin
               valid_n = 1'b0;
            end
            if (pc_redirect_valid) begin
               pc_n    = pc_redirect;
               state_n = RUN;
            end
         end
         STOP: begin
            if (advance) begin
               valid_n = 1'b0;
            end
         end
         default: state_n = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pc          <= RESET_PC;
         instr_valid <= 1'b0;
         icode       <= 4'h0;
         ifun        <= 4'h0;
         rA          <= 4'hF;
         rB          <= 4'hF;
         valC        <= '0;
         valP        <= '0;
         stat        <= AOK;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         instr_valid <= valid_n;
         icode       <= icode_n;
         ifun        <= ifun_n;
         rA          <= ra_n;
         rB          <= rb_n;
         valC        <= valc_n;
         valP        <= valp_n;
         stat        <= stat_n;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: byte-array instruction memory, a behavioural fetch model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_fetch_sequencer;

   logic        clk;
   logic        reset;
   logic [63:0] pc;
   logic        imem_error;
   logic [7:0]  byte0_bus;
   logic [71:0] byte19_bus;
   logic        advance;
   logic        pc_redirect_valid;
   logic [63:0] pc_redirect;
   logic        instr_valid;
   logic [3:0]  icode, ifun, rA, rB;
   logic [63:0] valC, valP;
   logic [1:0]  stat;

   fetch_sequencer dut (
      .clk(clk),
      .reset(reset),
      .pc(pc),
      .imem_error(imem_error),
      .Byte0(byte0_bus),
      .Byte19(byte19_bus),
      .advance(advance),
      .pc_redirect_valid(pc_redirect_valid),
      .pc_redirect(pc_redirect),
      .instr_valid(instr_valid),
      .icode(icode),
      .ifun(ifun),
      .rA(rA),
      .rB(rB),
      .valC(valC),
      .valP(valP),
      .stat(stat)
   );

   localparam logic [63:0] IMEM_LAST = 64'd2047;

   logic [7:0] mem [4096];
   int checks = 0;
   int errors = 0;
   bit check_en = 0;

   int len_tbl  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
   int maxf_tbl [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};

   logic [63:0] m_pc, m_valc, m_valp;
   logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
   logic [1:0]  m_stat;
   logic        m_valid;
   bit          m_wait, m_stop;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      byte0_bus  = mem[pc[11:0]];
      byte19_bus = '0;
      for (int k = 1; k <= 9; k++) begin
         byte19_bus[79-8*k -: 8] = mem[pc[11:0] + 12'(k)];
      end
   end

   function automatic logic [7:0] rd(input logic [63:0] a);
      return mem[a[11:0]];
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit adv, input bit rv,
                                input logic [63:0] tgt, input bit err);
      reset             = rst;
      advance           = adv;
      pc_redirect_valid = rv;
      pc_redirect       = tgt;
      imem_error        = err;
      @(negedge clk);
   endtask

   task automatic clearMem();
      for (int a = 0; a < 4096; a++) mem[a] = 8'h00;
   endtask

   // Reference fetch behaviour: what instruction sits at the model pc and what happens next.
   always @(posedge clk) begin : model
      logic [7:0]  op;
      logic [3:0]  ic, fn;
      logic [63:0] len, c;
      logic [1:0]  st;
      int          off;
      if (reset) begin
         m_pc = 64'd0; m_valid = 0; m_icode = 0; m_ifun = 0; m_ra = 4'hF; m_rb = 4'hF;
         m_valc = 0; m_valp = 0; m_stat = 0; m_wait = 0; m_stop = 0;
      end else if (m_stop) begin
         if (advance) m_valid = 0;
      end else if (m_wait) begin
         if (advance) m_valid = 0;
         if (pc_redirect_valid) begin
            m_pc   = pc_redirect;
            m_wait = 0;
         end
      end else if (!m_valid || advance) begin
         op  = rd(m_pc);
         ic  = op[7:4];
         fn  = op[3:0];
         len = 64'(len_tbl[ic]);
         c   = 0;
         off = (ic >= 4'h3 && ic <= 4'h5) ? 2 : ((ic == 4'h7 || ic == 4'h8) ? 1 : 0);
         if (off != 0) begin
            for (int k = 0; k < 8; k++) c = c | (64'(rd(m_pc + 64'(off + k))) << (8 * k));
         end
         if (imem_error || (m_pc + len - 1 > IMEM_LAST)) st = 2;
         else if (int'(fn) > maxf_tbl[ic])               st = 3;
         else if (ic == 4'h0)                             st = 1;
         else                                             st = 0;
         m_valid = 1;
         m_icode = (st == 2) ? 4'h0 : ic;
         m_ifun  = (st == 2) ? 4'h0 : fn;
         if (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) begin
            m_ra = rd(m_pc + 1)[7:4];
            m_rb = rd(m_pc + 1)[3:0];
         end else begin
            m_ra = 4'hF;
            m_rb = 4'hF;
         end
         m_valc = c;
         m_valp = m_pc + len;
         m_stat = st;
         if (st != 0)                                  m_stop = 1;
         else if (ic inside {4'h7, 4'h8, 4'h9})        m_wait = 1;
         else                                          m_pc   = m_pc + len;
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         checkOutput("m.pc",    pc,                m_pc);
         checkOutput("m.valid", 64'(instr_valid),  64'(m_valid));
         checkOutput("m.icode", 64'(icode),        64'(m_icode));
         checkOutput("m.ifun",  64'(ifun),         64'(m_ifun));
         checkOutput("m.rA",    64'(rA),           64'(m_ra));
         checkOutput("m.rB",    64'(rB),           64'(m_rb));
         checkOutput("m.valC",  valC,              m_valc);
         checkOutput("m.valP",  valP,              m_valp);
         checkOutput("m.stat",  64'(stat),         64'(m_stat));
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      clearMem();
      mem[0] = 8'h30; mem[1] = 8'hF8; mem[2] = 8'h08;
      mem[10] = 8'h30; mem[11] = 8'hF8; mem[12] = 8'h08;
      mem[20] = 8'h80; mem[21] = 8'h90;
      mem[111] = 8'h00; mem[112] = 8'h10; mem[113] = 8'h90;

      applyStimulus(1, 0, 0, 64'd0, 0);
      check_en = 1;
      applyStimulus(1, 0, 0, 64'd0, 0);
      checkOutput("rst.pc",    pc,               64'd0);
      checkOutput("rst.valid", 64'(instr_valid), 64'd0);
      checkOutput("rst.rA",    64'(rA),          64'hF);
      checkOutput("rst.valP",  valP,             64'd0);

      applyStimulus(0, 0, 0, 64'd0, 0);
      checkOutput("irmov.icode", 64'(icode), 64'h3);
      checkOutput("irmov.rB",    64'(rB),    64'h8);
      checkOutput("irmov.valC",  valC,       64'd8);
      checkOutput("irmov.valP",  valP,       64'd10);
      checkOutput("irmov.pc",    pc,         64'd10);

      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("seq.pc", pc, 64'd20);
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("call.icode", 64'(icode), 64'h8);
      checkOutput("call.valC",  valC,       64'h90);
      checkOutput("call.valP",  valP,       64'd29);
      checkOutput("call.pc",    pc,         64'd20);
      applyStimulus(0, 0, 0, 64'd0, 0);
      checkOutput("wait.pc", pc, 64'd20);
      applyStimulus(0, 1, 1, 64'd112, 0);
      checkOutput("redir.pc",    pc,               64'd112);
      checkOutput("redir.valid", 64'(instr_valid), 64'd0);
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("nop.icode", 64'(icode), 64'h1);
      checkOutput("nop.pc",    pc,         64'd113);
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("ret.icode", 64'(icode), 64'h9);
      checkOutput("ret.pc",    pc,         64'd113);
      applyStimulus(0, 0, 1, 64'd111, 0);
      checkOutput("ret.redir", pc, 64'd111);
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("halt.stat", 64'(stat), 64'd1);
      checkOutput("halt.valP", valP,      64'd112);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 1, 1, 64'd500, 0);
         checkOutput("stop.pc", pc, 64'd111);
      end
      checkOutput("stop.valid", 64'(instr_valid), 64'd0);
      applyStimulus(1, 0, 0, 64'd0, 0);
      checkOutput("rst2.pc", pc, 64'd0);

      clearMem();
      mem[0] = 8'h63; mem[1] = 8'h12; mem[2] = 8'hC0;
      applyStimulus(0, 0, 0, 64'd0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 0, 64'd0, 0);
         checkOutput("hold.pc",    pc,                                    64'd2);
         checkOutput("hold.out",   {40'd0, icode, ifun, rA, rB, valP[7:0]}, 64'h6312_02);
         checkOutput("hold.valid", 64'(instr_valid),                      64'd1);
      end
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("ins.stat", 64'(stat), 64'd3);
      checkOutput("ins.pc",   pc,        64'd2);

      applyStimulus(1, 0, 0, 64'd0, 0);
      clearMem();
      mem[0] = 8'h70; mem[1] = 8'hFD; mem[2] = 8'h07; mem[2045] = 8'h30;
      applyStimulus(0, 0, 0, 64'd0, 0);
      checkOutput("jmp.valC", valC, 64'd2045);
      applyStimulus(0, 0, 1, 64'd2045, 0);
      applyStimulus(0, 1, 0, 64'd0, 0);
      checkOutput("adr.stat",  64'(stat),  64'd2);
      checkOutput("adr.icode", 64'(icode), 64'd0);
      checkOutput("adr.pc",    pc,         64'd2045);

      applyStimulus(1, 0, 0, 64'd0, 0);
      applyStimulus(0, 0, 0, 64'd0, 0);
      applyStimulus(1, 1, 1, 64'd500, 0);
      checkOutput("rstwait.pc",    pc,               64'd0);
      checkOutput("rstwait.valid", 64'(instr_valid), 64'd0);
      applyStimulus(0, 0, 0, 64'd0, 1);
      checkOutput("imerr.stat", 64'(stat), 64'd2);

      for (int ep = 0; ep < 20; ep++) begin
         applyStimulus(1, 0, 0, 64'd0, 0);
         clearMem();
         for (int a = 0; a < 2100; a++) begin
            mem[a] = 8'(($urandom_range(0, 12) << 4) |
                        (($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0));
         end
         for (int cyc = 0; cyc < 150; cyc++) begin
            applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) == 0, 64'($urandom_range(0, 2060)),
                          $urandom_range(0, 99) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'd0, the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_LAST, default 64'd2047, the highest valid instruction-memory byte address.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pc  output  64  current fetch address driven to instruction memory.
REQ-006 SHALL have port imem_error  input  1  memory flags pc out of range.
REQ-007 SHALL have port Byte0  input  8  byte at pc: {icode, ifun}.
REQ-008 SHALL have port Byte19  input  72  bytes pc+1..pc+9; byte pc+1 is in [71:64] and byte pc+9 is in [7:0].
REQ-009 SHALL have port advance  input  1  downstream accepts the presented instruction this cycle.
REQ-010 SHALL have port pc_redirect_valid  input  1  resolved control-flow target is available.
REQ-011 SHALL have port pc_redirect  input  64  resolved target PC.
REQ-012 SHALL have ports instr_valid (1), icode (4), ifun (4), rA (4), rB (4), valC (64), valP (64), stat (2), all outputs and all registered.

Function
REQ-013 SHALL decode Byte0 and Byte19 combinationally from pc, and SHALL register the decoded result into the outputs on issue.
REQ-014 SHALL use these instruction lengths: icode 0, 1 and 9 are 1 byte; icode 2, 6, A and B are 2 bytes; icode 3, 4 and 5 are 10 bytes; icode 7 and 8 are 9 bytes.
REQ-015 SHALL treat as valid only: ifun 0 for icodes 0, 1, 3, 4, 5, 8, 9, A and B; ifun 0-6 for icodes 2 and 7; ifun 0-3 for icode 6.
REQ-016 SHALL take rA and rB from byte pc+1 (rA in the upper nibble) when the instruction has register IDs; otherwise rA and rB SHALL be 4'hF.
REQ-017 SHALL form valC little-endian from bytes pc+2..pc+9 for icodes 3, 4 and 5, from bytes pc+1..pc+8 for icodes 7 and 8, and SHALL set valC to 0 otherwise.
REQ-018 SHALL compute valP = pc + length, with 64-bit arithmetic and wrap ignored.
REQ-019 SHALL encode stat as AOK=0, HLT=1, ADR=2, INS=3, with priority ADR > INS > HLT > AOK.
REQ-020 SHALL report ADR when imem_error=1 or when pc+length-1 > IMEM_LAST; in that case icode SHALL be forced to 0 and ifun to 0.
REQ-021 SHALL implement FSM states RUN, WAIT_TGT and STOP.
REQ-022 SHALL issue in RUN when instr_valid=0 or advance=1; issue SHALL mean the outputs load the decode and instr_valid <= 1.
REQ-023 SHALL, on an issue with stat=AOK and icode not 7, 8 or 9, set pc <= valP and remain in RUN, giving one instruction per cycle under continuous advance.
REQ-024 SHALL, on an issue with icode 7, 8 or 9 and stat=AOK, hold pc and go to WAIT_TGT.
REQ-025 SHALL, on an issue with stat not AOK, hold pc and go to STOP.
REQ-026 SHALL, in RUN with instr_valid=1 and advance=0, hold pc and all outputs unchanged.
REQ-027 SHALL clear instr_valid (instr_valid <= 0) in WAIT_TGT or STOP when advance=1; otherwise the outputs SHALL hold.
REQ-028 SHALL, in WAIT_TGT with pc_redirect_valid=1, set pc <= pc_redirect and go to RUN; no issue SHALL occur that cycle, and the first issue SHALL occur on the next cycle.
REQ-029 SHALL ignore pc_redirect_valid in RUN and STOP.
REQ-030 SHALL, when advance and pc_redirect_valid are both 1 in WAIT_TGT, apply both in the same cycle.
REQ-031 SHALL leave STOP only through reset.

Reset
REQ-032 SHALL, on reset=1 at a clock edge, set pc=RESET_PC, state=RUN, instr_valid=0, icode=0, ifun=0, rA=F, rB=F, valC=0, valP=0 and stat=AOK.
REQ-033 SHALL have reset take priority over all other inputs, including in the middle of WAIT_TGT or STOP.

Verification
REQ-034 SHALL be verified by: reset, pc=0, Byte0=30, Byte19=F8_08_00.. -> after one edge, instr_valid=1, icode=3, rA=F, rB=8, valC=8, valP=10, stat=AOK, pc=10.
REQ-035 SHALL be verified by: pc=20, Byte0=80, Byte19=90_00.. -> valC=0x90, valP=29, WAIT_TGT, pc held at 20; then redirect=112 -> pc=112, and the next issue occurs one cycle later.
REQ-036 SHALL be verified by: pc=111, Byte0=00 -> stat=HLT, valP=112, STOP; pc remains 111 for 10 cycles under advance=1; then reset -> pc=0.
REQ-037 SHALL be verified by: Byte0=C0 -> stat=INS; and Byte0=63 with advance=0 for 3 cycles -> outputs and pc unchanged, instr_valid=1.
REQ-038 SHALL be verified by: pc=2045, Byte0=30 -> stat=ADR, icode=0, STOP; and imem_error=1 -> stat=ADR.
REQ-039 SHALL be verified by: reset asserted in WAIT_TGT together with pc_redirect_valid=1 -> pc=RESET_PC, state RUN, instr_valid=0.
